// File: rtl/serial_rx32_if.sv
// Parallel-side bundle of the serial word receiver: sample controls, serial input,
// and the word/handshake/status outputs.
interface serial_rx32_if #(
   parameter int WIDTH = 32
);
   logic             enb;
   logic             dir;
   logic             sIn;
   logic             ack;
   logic [WIDTH-1:0] Q;
   logic             valid;
   logic             busy;
   logic             ovr;
   logic             perr;

   modport master (output enb, dir, sIn, ack, input Q, valid, busy, ovr, perr);
   modport slave  (input enb, dir, sIn, ack, output Q, valid, busy, ovr, perr);
endinterface

// File: rtl/serial_rx32.sv
// Serial-to-parallel word receiver: start bit + WIDTH data bits, valid/ack handshake, sticky overrun.
// Optional trailing even-parity bit when SERIAL_RX32_PARITY_EN is defined.
//
// state   | meaning
// IDLE    | waiting for an enabled edge with sIn at the start level
// RECV    | collecting WIDTH data bits in the order latched at the start bit
// PAR     | sampling the parity bit (only with SERIAL_RX32_PARITY_EN)
module serial_rx32 #(
   parameter int   WIDTH     = 32,
   parameter logic START_LVL = 1'b1
) (
   input  logic          clk,
   input  logic          reset_L,
   serial_rx32_if.slave  rx
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
`ifdef SERIAL_RX32_PARITY_EN
      ST_PAR  = 2'd2,
`endif
      ST_RECV = 2'd1
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             ovr_q, ovr_d;
   logic             done;
   logic [WIDTH-1:0] shifted;
`ifdef SERIAL_RX32_PARITY_EN
   logic             perr_q, perr_d;
`endif

   assign shifted = dir_q ? {shreg_q[WIDTH-2:0], rx.sIn} : {rx.sIn, shreg_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      dir_d   = dir_q;
      q_d     = q_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      done    = 1'b0;
`ifdef SERIAL_RX32_PARITY_EN
      perr_d  = perr_q;
`endif
      if (rx.enb) begin
         case (state_q)
            ST_IDLE: begin
               if (rx.sIn == START_LVL) begin
                  state_d = ST_RECV;
                  cnt_d   = '0;
                  dir_d   = rx.dir;
               end
            end
            ST_RECV: begin
               shreg_d = shifted;
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SERIAL_RX32_PARITY_EN
                  state_d = ST_PAR;
`else
                  state_d = ST_IDLE;
                  q_d     = shifted;
                  done    = 1'b1;
`endif
               end
            end
`ifdef SERIAL_RX32_PARITY_EN
            ST_PAR: begin
               state_d = ST_IDLE;
               q_d     = shreg_q;
               perr_d  = (^shreg_q) ^ rx.sIn;
               done    = 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end

      // Handshake runs on every edge, independent of the sample enable.
      if (done) begin
         valid_d = 1'b1;
         if (valid_q && !rx.ack) ovr_d = 1'b1;
         else if (rx.ack)        ovr_d = 1'b0;
      end else if (rx.ack) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         dir_q   <= 1'b0;
         q_q     <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef SERIAL_RX32_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         dir_q   <= dir_d;
         q_q     <= q_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
`ifdef SERIAL_RX32_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign rx.Q     = q_q;
   assign rx.valid = valid_q;
   assign rx.busy  = busy_q;
   assign rx.ovr   = ovr_q;
`ifdef SERIAL_RX32_PARITY_EN
   assign rx.perr  = perr_q;
`else
   assign rx.perr  = 1'b0;
`endif
endmodule

// File: tb/tb_serial_rx32.sv
// Directed bench for serial_rx32: table of whole frames plus hand sequences for
// overrun, ack-on-completion, mid-frame reset and (when enabled) parity.
module tb_serial_rx32;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset_L;
   always #5 clk = ~clk;

   serial_rx32_if #(.WIDTH(W)) bus ();
   serial_rx32 #(.WIDTH(W), .START_LVL(1'b1)) dut (.clk(clk), .reset_L(reset_L), .rx(bus));

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] word;
      logic        d;
      int          toggle_at;
      logic        gated;
      logic        par_bit;
      logic [31:0] exp_q;
      logic        exp_perr;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic gap();
      bus.enb = 1'b0;
      bus.sIn = ~bus.sIn;
      @(negedge clk);
      check("busy_hold_gap", {31'd0, bus.busy}, 32'd1);
   endtask

   task automatic ack_pulse();
      bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] w, input logic d, input int tog,
                             input logic gated, input logic par_bit, input logic ack_last);
      logic last_is_data;
`ifdef SERIAL_RX32_PARITY_EN
      last_is_data = 1'b0;
`else
      last_is_data = 1'b1;
`endif
      bus.dir = d;
      bus.sIn = 1'b1;
      bus.enb = 1'b1;
      @(negedge clk);
      if (gated) gap();
      for (int i = 0; i < 32; i++) begin
         if (i == tog) bus.dir = ~d;
         bus.sIn = d ? w[31-i] : w[i];
         bus.enb = 1'b1;
         if (ack_last && last_is_data && i == 31) bus.ack = 1'b1;
         @(negedge clk);
         bus.ack = 1'b0;
         if (gated && (i < 31 || !last_is_data)) gap();
      end
`ifdef SERIAL_RX32_PARITY_EN
      bus.sIn = par_bit;
      bus.enb = 1'b1;
      if (ack_last) bus.ack = 1'b1;
      @(negedge clk);
      bus.ack = 1'b0;
`endif
      bus.enb = 1'b0;
      bus.sIn = 1'b0;
   endtask

   initial begin
      //          word           dir  tog gated par  exp_q          perr
      vecs[0] = '{32'hDEADBEEF, 1'b1, -1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
      vecs[1] = '{32'h80000001, 1'b0,  5, 1'b0, 1'b0, 32'h80000001, 1'b0};
      vecs[2] = '{32'h12345678, 1'b1, -1, 1'b1, 1'b1, 32'h12345678, 1'b0};
      vecs[3] = '{32'hA5A5A5A5, 1'b0, -1, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0};
      vecs[4] = '{32'h00000000, 1'b1, -1, 1'b0, 1'b0, 32'h00000000, 1'b0};
      vecs[5] = '{32'hFFFFFFFF, 1'b0, 20, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0};

      bus.enb = 1'b0; bus.dir = 1'b0; bus.sIn = 1'b0; bus.ack = 1'b0;
      reset_L = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_q",     bus.Q, 32'd0);
      check("rst_valid", {31'd0, bus.valid}, 32'd0);
      check("rst_busy",  {31'd0, bus.busy}, 32'd0);
      check("rst_ovr",   {31'd0, bus.ovr}, 32'd0);
      check("rst_perr",  {31'd0, bus.perr}, 32'd0);
      reset_L = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         send_frame(vecs[v].word, vecs[v].d, vecs[v].toggle_at, vecs[v].gated, vecs[v].par_bit, 1'b0);
         check("vec_q",     bus.Q, vecs[v].exp_q);
         check("vec_valid", {31'd0, bus.valid}, 32'd1);
         check("vec_busy",  {31'd0, bus.busy}, 32'd0);
         check("vec_ovr",   {31'd0, bus.ovr}, 32'd0);
         check("vec_perr",  {31'd0, bus.perr}, {31'd0, vecs[v].exp_perr});
         ack_pulse();
         check("vec_ack_valid", {31'd0, bus.valid}, 32'd0);
      end

      // Overrun: two frames back to back, no ack.
      send_frame(32'h00000001, 1'b1, -1, 1'b0, 1'b1, 1'b0);
      check("ovr1_q",     bus.Q, 32'h00000001);
      check("ovr1_ovr",   {31'd0, bus.ovr}, 32'd0);
      send_frame(32'h00000002, 1'b1, -1, 1'b0, 1'b1, 1'b0);
      check("ovr2_q",     bus.Q, 32'h00000002);
      check("ovr2_valid", {31'd0, bus.valid}, 32'd1);
      check("ovr2_ovr",   {31'd0, bus.ovr}, 32'd1);
      ack_pulse();
      check("ovr_ack_valid", {31'd0, bus.valid}, 32'd0);
      check("ovr_ack_ovr",   {31'd0, bus.ovr}, 32'd0);

      // Word completes on the same edge as ack: valid stays, no overrun.
      send_frame(32'h00000011, 1'b0, -1, 1'b0, 1'b0, 1'b0);
      send_frame(32'h00000022, 1'b0, -1, 1'b0, 1'b0, 1'b1);
      check("ackc_q",     bus.Q, 32'h00000022);
      check("ackc_valid", {31'd0, bus.valid}, 32'd1);
      check("ackc_ovr",   {31'd0, bus.ovr}, 32'd0);
      ack_pulse();
      ack_pulse();
      check("ack_idle_valid", {31'd0, bus.valid}, 32'd0);

      // Reset mid-frame after data bit 10, with a pending word and overrun.
      send_frame(32'h00000007, 1'b1, -1, 1'b0, 1'b1, 1'b0);
      send_frame(32'h00000007, 1'b1, -1, 1'b0, 1'b1, 1'b0);
      check("pre_rst_ovr", {31'd0, bus.ovr}, 32'd1);
      bus.dir = 1'b1; bus.sIn = 1'b1; bus.enb = 1'b1;
      @(negedge clk);
      for (int i = 0; i <= 10; i++) begin
         bus.sIn = i[0];
         @(negedge clk);
      end
      check("mid_busy", {31'd0, bus.busy}, 32'd1);
      reset_L = 1'b0;
      bus.sIn = 1'b1;
      @(negedge clk);
      check("mrst_q",     bus.Q, 32'd0);
      check("mrst_valid", {31'd0, bus.valid}, 32'd0);
      check("mrst_busy",  {31'd0, bus.busy}, 32'd0);
      check("mrst_ovr",   {31'd0, bus.ovr}, 32'd0);
      check("mrst_perr",  {31'd0, bus.perr}, 32'd0);
      reset_L = 1'b1;
      bus.enb = 1'b0; bus.sIn = 1'b0;
      @(negedge clk);
      send_frame(32'hA5A5A5A5, 1'b1, -1, 1'b0, 1'b0, 1'b0);
      check("post_rst_q",     bus.Q, 32'hA5A5A5A5);
      check("post_rst_valid", {31'd0, bus.valid}, 32'd1);
      check("post_rst_ovr",   {31'd0, bus.ovr}, 32'd0);
      ack_pulse();

`ifdef SERIAL_RX32_PARITY_EN
      send_frame(32'h00000003, 1'b1, -1, 1'b0, 1'b1, 1'b0);
      check("par_bad_perr", {31'd0, bus.perr}, 32'd1);
      check("par_bad_q",    bus.Q, 32'h00000003);
      ack_pulse();
      send_frame(32'h00000003, 1'b0, -1, 1'b0, 1'b0, 1'b0);
      check("par_ok_perr", {31'd0, bus.perr}, 32'd0);
      check("par_ok_q",    bus.Q, 32'h00000003);
      ack_pulse();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/serial_rx32.md
# serial_rx32

Serial-to-parallel word receiver for the 32-bit shift-register datapath. It accepts the serial stream produced by the shift chain's `sOut` output and rebuilds the parallel word, honouring the same bit-order control (`dir`) and clock-enable gating (`enb`). It detects a start bit, collects `WIDTH` data bits, and presents the word on `Q` with a valid/acknowledge handshake and an overrun flag. It sits at the receiving end of any serial link driven by the shift-register chain.

## Interface
- `WIDTH`, default 32: data bits per frame; minimum 2.
- `START_LVL`, default 1: `sIn` level that marks a start bit while idle.

- `clk`  in  1: clock; all state updates on the rising edge.
- `reset_L`  in  1: synchronous reset, active low.
- `enb`  in  1: bit-sample enable. `sIn` is examined only on edges where `enb`=1.
- `dir`  in  1: bit order. 1 = MSB-first, so the first data bit lands in `Q[WIDTH-1]`. 0 = LSB-first, so the first data bit lands in `Q[0]`.
- `sIn`  in  1: serial data in.
- `ack`  in  1: consumer acknowledge for `valid`.
- `Q`  out  WIDTH: last completed word; registered.
- `valid`  out  1: `Q` holds an unacknowledged word.
- `busy`  out  1: a frame is in progress (state not IDLE).
- `ovr`  out  1: sticky overrun flag. It is set when a word completes while `valid`=1 and `ack`=0.
- `perr`  out  1: parity error for the word in `Q`. It is always 0 unless `SERIAL_RX32_PARITY_EN` is defined.

## Operation
- States: IDLE, RECV, PAR. PAR exists only with the parity macro.
- IDLE:
  - On an `enb`=1 edge with `sIn`==`START_LVL`: go to RECV, clear the bit counter, and latch `dir` into an internal `dir_q`.
  - Otherwise stay in IDLE.
- RECV, on each `enb`=1 edge:
  - `dir_q`=1: shift left, shreg = {shreg[WIDTH-2:0], sIn}.
  - `dir_q`=0: shift right, shreg = {sIn, shreg[WIDTH-1:1]}.
  - Increment the counter, which is `$clog2(WIDTH)` bits.
  - On the edge that samples bit WIDTH-1:
    - Without parity: load `Q` with the completed word, set `valid`, and return to IDLE.
    - With parity: go to PAR.
- `enb`=0 in any state: hold all state. Frames may be stretched arbitrarily.
- Changes to `dir` mid-frame are ignored; `dir_q` governs the whole frame.
- Handshake:
  - On an edge with `valid`=1 and `ack`=1, `valid` clears, unless a word completes on the same edge.
  - `ack` while `valid`=0 has no effect.
- Word completes with `valid`=1 and `ack`=0:
  - `Q` is overwritten with the new word.
  - `valid` stays 1 and `ovr` is set.
- Word completes on the same edge as `ack`: `Q` loads, `valid` stays 1, and `ovr` is not set.
- `ovr` clears on the next edge with `ack`=1 that is not itself an overrun.
- A start level on `sIn` during RECV is ordinary data. No resynchronisation happens mid-frame.

## Timing
- Reset (`reset_L`=0 at an edge): state=IDLE, counter=0, shreg=0, `Q`=0, `valid`=0, `busy`=0, `ovr`=0, `perr`=0. Reset overrides every other input, including mid-frame.
- Latency, counted in enabled edges:
  - Start bit sampled at enabled edge 0; data bits at enabled edges 1..WIDTH.
  - `Q`/`valid` are visible after enabled edge WIDTH, or WIDTH+1 with parity.
- `busy` rises after the start-bit edge. It falls after the edge that loads `Q`.
- A new start bit can be accepted on the enabled edge right after `Q` loads, so back-to-back frames are supported.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- `SERIAL_RX32_PARITY_EN` defined:
  - After the WIDTH data bits, one parity bit is sampled in PAR on the next `enb`=1 edge.
  - Parity is even over data plus parity bit.
  - At that edge, `Q` and `valid` load, `perr` = XOR(data, parity bit), and the state returns to IDLE.
  - `perr` updates with every loaded word.
- Not defined: there is no PAR state, the frame is start + WIDTH bits, and `perr` is tied to 0.

## Test plan
- MSB-first, `dir`=1, `enb`=1 constantly: send start bit then 0xDEADBEEF MSB first. Required: `Q`=0xDEADBEEF and `valid`=1 after the 33rd edge, `busy`=0, `ovr`=0.
- LSB-first, `dir`=0: send start bit then 0x80000001 LSB first, and toggle `dir` at bit 5. Required: `Q`=0x80000001, confirming `dir` is latched at the start bit.
- Enable gating: `enb` high every other cycle, send 0x12345678. Required: `Q`=0x12345678 after 66 clocks, and state holds on every `enb`=0 cycle.
- Overrun: send 0x00000001 then 0x00000002 back to back with `ack`=0. Required: `Q`=0x00000002, `valid`=1, `ovr`=1. Then pulse `ack`: `valid`=0 and `ovr`=0 on the next edge.
- Reset mid-frame: pull `reset_L` low after data bit 10. Required: all outputs 0 and `busy`=0. A following frame of 0xA5A5A5A5 is then received correctly.
- With `SERIAL_RX32_PARITY_EN`: send 0x00000003 with parity bit 1. Required: `perr`=1. Send the same word with parity bit 0. Required: `perr`=0, `Q`=0x00000003.
